design_1_s2mm: RTL and testbench
================================

DESIGN_1_S2MM -- requirements
Module: design_1_s2mm

Interface
REQ-001 SHALL be one clock and one reset: reset is asynchronous and active-low (clk, resetn).
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 axis_in_tdata in 128, axis_in_tkeep in 16 (byte enables, bit i = bytes 8i+7:8i), axis_in_tlast in 1, axis_in_tvalid in 1, axis_in_tready out 1: 128-bit AXI4-Stream sink.
REQ-005 s_axi_control_awaddr in 6, awvalid in 1, awready out 1; wdata in 32, wstrb in 4, wvalid in 1, wready out 1; bresp out 2, bvalid out 1, bready in 1: AXI4-Lite write channels.
REQ-006 s_axi_control_araddr in 6, arvalid in 1, arready out 1; rdata out 32, rresp out 2, rvalid out 1, rready in 1: AXI4-Lite read channels.
REQ-007 Parameter MEM_DEPTH, default 64: number of 128-bit words in the internal destination memory.

Function
REQ-008 Register map (byte offsets): 0x00 CTRL, 0x10 ADDR_LO, 0x14 ADDR_HI, 0x18 SIZE (in 128-bit beats), 0x1C COUNT (read-only, beats written), 0x20 RD_IDX, 0x24/0x28/0x2C/0x30 MEM word bits 31:0/63:32/95:64/127:96 of mem[RD_IDX].
REQ-009 CTRL bits: 0 ap_start (write 1 sets), 1 ap_done (clear-on-read), 2 ap_idle, 3 ap_ready (clear-on-read); other bits read 0.
REQ-010 Writes honour wstrb per byte; writes to read-only or unmapped offsets are ignored; reads of unmapped offsets return 0; bresp and rresp always 00.
REQ-011 Write path: AW and W accepted independently (awready/wready high when the respective holding slot is empty); register updated and bvalid asserted the cycle after both are held; bvalid held until bready.
REQ-012 Read path: arready high when no rvalid pending; rvalid asserted the cycle after the AR handshake with rdata; held until rready.
REQ-013 Transfer start: when idle and ap_start=1, latch base = ADDR_LO[31:4] and beats = SIZE, clear COUNT, clear ap_idle, clear ap_start.
REQ-014 Running: axis_in_tready=1 while COUNT < beats; each tvalid&tready beat writes tdata into mem[(base+COUNT) mod MEM_DEPTH] with per-byte tkeep enables, then COUNT increments.
REQ-015 axis_in_tlast is ignored; completion is purely by SIZE beat count; ADDR_HI is stored only.
REQ-016 Completion: the cycle after the beat that makes COUNT == beats, set ap_done and ap_ready, set ap_idle, tready=0.
REQ-017 SIZE = 0: transfer completes the cycle after start with no memory write.
REQ-018 ADDR/SIZE writes during a transfer update registers but affect only the next start; ap_start writes while running are held and begin the next transfer after completion.
REQ-019 axis_in_tready SHALL be 0 while idle; stream data offered while idle is not consumed.
REQ-020 Simultaneous CTRL read and done event: done/ready set wins (not cleared by that read).

Reset
REQ-021 On resetn low: all AXI outputs valid/ready low except awready, wready, arready become 1 after reset release; axis_in_tready=0; CTRL = ap_idle only (0x4); ADDR_LO/HI, SIZE, COUNT, RD_IDX = 0; in-flight transfer aborted.
REQ-022 Memory contents are not reset.

Verification
REQ-023 Write ADDR_LO=0xC0000000, SIZE=6, CTRL=1; stream 3 beats of tdata 0x..2211 increments plus 3 more (tlast on beat 3 and 6) -> all 6 accepted, COUNT=6, CTRL reads 0xE then 0x4.
REQ-024 After REQ-023, RD_IDX=0 -> MEM words return beat 0 data; RD_IDX=5 -> beat 5 data.
REQ-025 tkeep=0x00FF on one beat -> upper 8 bytes of that mem word retain prior value.
REQ-026 SIZE=0, start -> ap_done next cycle, tready never asserted, COUNT=0.
REQ-027 ADDR_LO=0x3F0 (base 63), SIZE=2 -> beats land in mem[63] and mem[0] (wrap).
REQ-028 Assert resetn low mid-transfer -> tready=0, CTRL reads 0x4, COUNT=0; new start works normally.

Source files
------------

// File: rtl/design_1_s2mm.sv
// Stream-to-memory mover: a started transfer stores SIZE 128-bit beats into consecutive
// (wrapping) words of an internal memory starting at ADDR_LO/16, under AXI4-Lite control.
module design_1_s2mm #(
  parameter int MEM_DEPTH = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [127:0] axis_in_tdata,
  input  logic [15:0]  axis_in_tkeep,
  input  logic         axis_in_tlast,
  input  logic         axis_in_tvalid,
  output logic         axis_in_tready,
  input  logic [5:0]   s_axi_control_awaddr,
  input  logic         s_axi_control_awvalid,
  output logic         s_axi_control_awready,
  input  logic [31:0]  s_axi_control_wdata,
  input  logic [3:0]   s_axi_control_wstrb,
  input  logic         s_axi_control_wvalid,
  output logic         s_axi_control_wready,
  output logic [1:0]   s_axi_control_bresp,
  output logic         s_axi_control_bvalid,
  input  logic         s_axi_control_bready,
  input  logic [5:0]   s_axi_control_araddr,
  input  logic         s_axi_control_arvalid,
  output logic         s_axi_control_arready,
  output logic [31:0]  s_axi_control_rdata,
  output logic [1:0]   s_axi_control_rresp,
  output logic         s_axi_control_rvalid,
  input  logic         s_axi_control_rready
);
  localparam int          AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  localparam logic [5:0] A_CTRL    = 6'h00;
  localparam logic [5:0] A_ADDR_LO = 6'h10;
  localparam logic [5:0] A_ADDR_HI = 6'h14;
  localparam logic [5:0] A_SIZE    = 6'h18;
  localparam logic [5:0] A_COUNT   = 6'h1C;
  localparam logic [5:0] A_RD_IDX  = 6'h20;
  localparam logic [5:0] A_MEM0    = 6'h24;
  localparam logic [5:0] A_MEM1    = 6'h28;
  localparam logic [5:0] A_MEM2    = 6'h2C;
  localparam logic [5:0] A_MEM3    = 6'h30;

  logic [15:0][7:0] mem [MEM_DEPTH];

  logic          ready_en;
  logic          aw_full, w_full;
  logic [5:0]    aw_addr;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          ap_start, ap_done, ap_idle, ap_ready;
  logic [31:0]   addr_lo, addr_hi, size, count, rd_idx, beats;
  logic [27:0]   base;
  logic          do_write, start_wr, ctrl_rd, ar_hs, beat, finish;
  logic [31:0]   wr_sum, wr_mod, rd_mod, rd_mux;
  logic [AW-1:0] wr_idx, rd_word_idx;
  logic [127:0]  rd_word;
  logic          unused;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Ready outputs stay low until the first clock after reset release.
  assign s_axi_control_awready = ready_en & ~aw_full;
  assign s_axi_control_wready  = ready_en & ~w_full;
  assign s_axi_control_arready = ready_en & ~s_axi_control_rvalid;
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_rresp   = 2'b00;

  assign do_write = aw_full & w_full & ~s_axi_control_bvalid;
  assign start_wr = do_write & (aw_addr == A_CTRL) & w_strb[0] & w_data[0];
  assign ar_hs    = s_axi_control_arvalid & s_axi_control_arready;
  assign ctrl_rd  = ar_hs & (s_axi_control_araddr == A_CTRL);

  assign axis_in_tready = ~ap_idle & (count < beats);
  assign beat           = axis_in_tvalid & axis_in_tready;
  assign finish         = ~ap_idle & (count == beats);

  assign wr_sum      = {4'd0, base} + count;
  assign wr_mod      = wr_sum % DEPTH;
  assign wr_idx      = wr_mod[AW-1:0];
  assign rd_mod      = rd_idx % DEPTH;
  assign rd_word_idx = rd_mod[AW-1:0];
  assign rd_word     = mem[rd_word_idx];

  // Completion is by beat count only; tlast carries no meaning here.
  assign unused = ^{axis_in_tlast, wr_mod[31:AW], rd_mod[31:AW]};

  always_comb begin
    rd_mux = '0;
    case (s_axi_control_araddr)
      A_CTRL:    rd_mux = {28'd0, ap_ready, ap_idle, ap_done, ap_start};
      A_ADDR_LO: rd_mux = addr_lo;
      A_ADDR_HI: rd_mux = addr_hi;
      A_SIZE:    rd_mux = size;
      A_COUNT:   rd_mux = count;
      A_RD_IDX:  rd_mux = rd_idx;
      A_MEM0:    rd_mux = rd_word[31:0];
      A_MEM1:    rd_mux = rd_word[63:32];
      A_MEM2:    rd_mux = rd_word[95:64];
      A_MEM3:    rd_mux = rd_word[127:96];
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en             <= 1'b0;
      aw_full              <= 1'b0;
      w_full               <= 1'b0;
      aw_addr              <= '0;
      w_data               <= '0;
      w_strb               <= '0;
      s_axi_control_bvalid <= 1'b0;
      s_axi_control_rvalid <= 1'b0;
      s_axi_control_rdata  <= '0;
      ap_start             <= 1'b0;
      ap_done              <= 1'b0;
      ap_idle              <= 1'b1;
      ap_ready             <= 1'b0;
      addr_lo              <= '0;
      addr_hi              <= '0;
      size                 <= '0;
      count                <= '0;
      rd_idx               <= '0;
      beats                <= '0;
      base                 <= '0;
    end else begin
      ready_en <= 1'b1;
      if (s_axi_control_awvalid && s_axi_control_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_control_awaddr;
      end
      if (s_axi_control_wvalid && s_axi_control_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_control_wdata;
        w_strb <= s_axi_control_wstrb;
      end
      if (s_axi_control_bvalid && s_axi_control_bready) s_axi_control_bvalid <= 1'b0;
      if (do_write) begin
        aw_full              <= 1'b0;
        w_full               <= 1'b0;
        s_axi_control_bvalid <= 1'b1;
        case (aw_addr)
          A_ADDR_LO: addr_lo <= merge(addr_lo, w_data, w_strb);
          A_ADDR_HI: addr_hi <= merge(addr_hi, w_data, w_strb);
          A_SIZE:    size    <= merge(size, w_data, w_strb);
          A_RD_IDX:  rd_idx  <= merge(rd_idx, w_data, w_strb);
          default: ;
        endcase
      end

      if (s_axi_control_rvalid && s_axi_control_rready) s_axi_control_rvalid <= 1'b0;
      if (ar_hs) begin
        s_axi_control_rvalid <= 1'b1;
        s_axi_control_rdata  <= rd_mux;
      end

      // A start written while running stays pending until the engine is idle again.
      ap_start <= (ap_start & ~ap_idle) | start_wr;
      if (ap_idle && ap_start) begin
        base    <= addr_lo[31:4];
        beats   <= size;
        count   <= '0;
        ap_idle <= 1'b0;
      end else if (!ap_idle) begin
        if (beat)   count   <= count + 32'd1;
        if (finish) ap_idle <= 1'b1;
      end

      // The done event overrides a clear-on-read in the same cycle.
      if (ctrl_rd) begin
        ap_done  <= 1'b0;
        ap_ready <= 1'b0;
      end
      if (finish) begin
        ap_done  <= 1'b1;
        ap_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int i = 0; i < 16; i++)
        if (axis_in_tkeep[i]) mem[wr_idx][i] <= axis_in_tdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_design_1_s2mm.sv
// Randomised bench: AXI4-Lite reads are scoreboarded against a word-level model of
// the register file and destination memory built from the bench's own stimulus.
module tb_design_1_s2mm;
  localparam int DEPTH = 64;

  logic         clk = 1'b0, resetn = 1'b0;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast, tvalid, tready;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  design_1_s2mm dut (
    .clk(clk), .resetn(resetn),
    .axis_in_tdata(tdata), .axis_in_tkeep(tkeep), .axis_in_tlast(tlast),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready),
    .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb), .s_axi_control_wvalid(wvalid),
    .s_axi_control_wready(wready), .s_axi_control_bresp(bresp), .s_axi_control_bvalid(bvalid),
    .s_axi_control_bready(bready), .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid),
    .s_axi_control_arready(arready), .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready)
  );

  typedef struct packed { logic [5:0] addr; logic [31:0] exp; } sb_t;
  sb_t sb[$];
  int  n_checks = 0, n_fail = 0;
  bit  saw_tready;

  logic [127:0] m_mem [DEPTH];
  logic [31:0]  m_ctrl, m_addr_lo, m_addr_hi, m_size, m_rd_idx;
  int           m_base, m_k, m_beats;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed read response is matched to the oldest expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rvalid && rready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h with no read outstanding", rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.exp || rresp !== 2'b00) begin
          n_fail++;
          $display("FAIL rd_0x%02h: got %h resp %0d, expected %h resp 0", e.addr, rdata, rresp, e.exp);
        end
      end
    end
  end

  always @(negedge clk) if (tready) saw_tready = 1'b1;

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [5:0] a);
    logic [127:0] w;
    w = m_mem[m_rd_idx % DEPTH];
    case (a)
      6'h00: return m_ctrl;
      6'h10: return m_addr_lo;
      6'h14: return m_addr_hi;
      6'h18: return m_size;
      6'h1C: return 32'(m_k);
      6'h20: return m_rd_idx;
      6'h24: return w[31:0];
      6'h28: return w[63:32];
      6'h2C: return w[95:64];
      6'h30: return w[127:96];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 32'h4; m_addr_lo = 0; m_addr_hi = 0; m_size = 0; m_rd_idx = 0;
    m_k = 0; m_beats = 0; m_base = 0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int wd;
    bit aw_hs, w_hs, aw_done, w_done, b_hs;
    wd = $urandom_range(0, 2);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = (wd == 0);
    aw_done = 0; w_done = 0;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
      if (!w_done && c + 1 >= wd) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("axi_write_timeout", 1'b0, 1'b1);
    bready = 1'b1; b_hs = 0;
    for (int c = 0; c < 50 && !b_hs; c++) begin
      @(negedge clk);
      b_hs = bvalid;
      if (b_hs) check("bresp", bresp, 2'b00);
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!b_hs) check("bvalid_timeout", 1'b0, 1'b1);
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_write(a, d, s);
    case (a)
      6'h10: m_addr_lo = merge(m_addr_lo, d, s);
      6'h14: m_addr_hi = merge(m_addr_hi, d, s);
      6'h18: m_size    = merge(m_size, d, s);
      6'h20: m_rd_idx  = merge(m_rd_idx, d, s);
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [5:0] a);
    sb_t e;
    bit hs;
    e.addr = a;
    e.exp  = model_rd(a);
    if (a == 6'h00) m_ctrl = m_ctrl & ~32'hA;
    sb.push_back(e);
    araddr = a; arvalid = 1'b1; hs = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 1'b0, 1'b1);
  endtask

  task automatic read_mem(input logic [31:0] idx);
    reg_write(6'h20, idx, 4'hF);
    reg_read(6'h24); reg_read(6'h28); reg_read(6'h2C); reg_read(6'h30);
  endtask

  task automatic begin_xfer();
    m_base = int'(m_addr_lo >> 4);
    m_beats = int'(m_size);
    m_k = 0;
  endtask

  task automatic start();
    reg_write(6'h00, 32'h1, 4'hF);
  endtask

  task automatic finish_xfer();
    repeat (3) begin @(posedge clk); #1; end
    m_ctrl = 32'hE;
  endtask

  // mode 0: random data, full keep; 1: incrementing byte pattern, tlast every third beat;
  // 2: random keep, first beat keeps only the low 8 bytes.
  task automatic stream(input int n, input int mode);
    logic [127:0] d, w;
    logic [15:0]  kp;
    bit hs;
    int idx;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int b = 0; b < 16; b++)
        d[8*b +: 8] = (mode == 1) ? 8'((17 * (b + 1) + m_k) & 255) : 8'($urandom);
      kp = (mode != 2) ? 16'hFFFF : (j == 0) ? 16'h00FF : 16'($urandom);
      tdata = d; tkeep = kp;
      tlast = (mode == 1) ? ((j % 3) == 2) : 1'($urandom_range(0, 1));
      tvalid = 1'b1; hs = 0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        hs = tready;
        @(posedge clk); #1;
      end
      tvalid = 1'b0;
      if (!hs) check("tready_timeout", 1'b0, 1'b1);
      else begin
        idx = (m_base + m_k) % DEPTH;
        w = m_mem[idx];
        for (int b = 0; b < 16; b++) if (kp[b]) w[8*b +: 8] = d[8*b +: 8];
        m_mem[idx] = w;
        m_k++;
      end
      @(negedge clk);
      check("tready_after_beat", tready, 1'(m_k < m_beats));
      @(posedge clk); #1;
    end
  endtask

  task automatic offer_idle(input string name, input int cycles);
    tdata = {4{$urandom}}; tkeep = 16'hFFFF; tvalid = 1'b1;
    saw_tready = 0;
    repeat (cycles) begin @(posedge clk); #1; end
    @(negedge clk);
    check(name, saw_tready, 1'b0);
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin @(posedge clk); #1; end
    if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic xfer(input logic [31:0] addr, input int n, input int mode);
    reg_write(6'h10, addr, 4'hF);
    reg_write(6'h18, 32'(n), 4'hF);
    start();
    begin_xfer();
    stream(n, mode);
    finish_xfer();
    reg_read(6'h00); reg_read(6'h00); reg_read(6'h1C);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    tdata = '0; tkeep = '0; tlast = 0; tvalid = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", tready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    reg_read(6'h00); reg_read(6'h10); reg_read(6'h14); reg_read(6'h18);
    reg_read(6'h1C); reg_read(6'h20); reg_read(6'h3C);
    offer_idle("idle_not_consumed", 6);

    // Fill every word so later reads are fully defined.
    xfer(32'h0, DEPTH, 0);

    xfer(32'hC000_0000, 6, 1);
    read_mem(0); read_mem(5);

    reg_write(6'h10, 32'hFFFF_FFFF, 4'hF);
    reg_write(6'h10, 32'h1234_5678, 4'h5);
    reg_read(6'h10);
    reg_write(6'h14, 32'hDEAD_BEEF, 4'hC);
    reg_read(6'h14);
    reg_write(6'h1C, 32'hFF, 4'hF);
    reg_write(6'h3C, 32'h55, 4'hF);
    reg_read(6'h1C); reg_read(6'h3C);

    xfer(32'h0000_0070, 3, 2);
    read_mem(7); read_mem(8);

    reg_write(6'h18, 32'h0, 4'hF);
    tdata = {4{$urandom}}; tkeep = 16'hFFFF; tvalid = 1'b1;
    saw_tready = 0;
    start();
    begin_xfer();
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("size0_no_tready", saw_tready, 1'b0);
    @(posedge clk); #1;
    tvalid = 1'b0;
    m_ctrl = 32'hE;
    reg_read(6'h00); reg_read(6'h1C); reg_read(6'h00);

    xfer(32'h0000_03F0, 2, 0);
    read_mem(63); read_mem(0);

    // Start written mid-transfer runs after the current one, with the updated registers.
    reg_write(6'h10, 32'h100, 4'hF);
    reg_write(6'h18, 32'd3, 4'hF);
    start();
    begin_xfer();
    stream(1, 0);
    reg_write(6'h18, 32'd2, 4'hF);
    reg_write(6'h10, 32'h200, 4'hF);
    start();
    stream(2, 0);
    begin_xfer();
    stream(2, 2);
    finish_xfer();
    reg_read(6'h00); reg_read(6'h1C);
    read_mem(16); read_mem(18); read_mem(32); read_mem(33);

    for (int t = 0; t < 4; t++) begin
      a = $urandom;
      n = $urandom_range(1, 8);
      xfer(a, n, 2);
      for (int k = 0; k < n; k++) read_mem(32'((int'(a >> 4) + k) % DEPTH));
    end
    read_mem(32'd64 + 32'd3);

    // Reset in the middle of a transfer.
    reg_write(6'h10, 32'h40, 4'hF);
    reg_write(6'h18, 32'd10, 4'hF);
    start();
    begin_xfer();
    stream(3, 0);
    drain();
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_tready", tready, 1'b0);
    check("midrst_valids", {bvalid, rvalid}, 2'b00);
    @(posedge clk); #1 resetn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reg_read(6'h00); reg_read(6'h1C); reg_read(6'h10); reg_read(6'h18);
    offer_idle("midrst_idle", 4);
    read_mem(4); read_mem(6);
    xfer(32'h50, 4, 0);
    read_mem(5); read_mem(8);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
